// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the reg_file write port between the ALU and load-return paths,
// tracks outstanding loads in a per-register scoreboard and raises decode stalls on hazards.
module wb_port_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [A_WIDTH-1:0]    alu_rd,
    input  logic [D_WIDTH-1:0]    alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [A_WIDTH-1:0]    ld_rd,
    input  logic [D_WIDTH-1:0]    ld_data,
    output logic                  ld_ready,
    input  logic                  issue_vld,
    input  logic [A_WIDTH-1:0]    issue_rd,
    input  logic [A_WIDTH-1:0]    chk_rs1,
    input  logic [A_WIDTH-1:0]    chk_rs2,
    input  logic [A_WIDTH-1:0]    chk_rd,
    output logic                  stall,
    output logic                  WE3,
    output logic [A_WIDTH-1:0]    AD3,
    output logic [D_WIDTH-1:0]    WD3,
    output logic [2**A_WIDTH-1:0] busy,
    output logic                  sb_err
);

    localparam int NREG = 2**A_WIDTH;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_t;

    rr_t             rr_last;
    logic            alu_elig;
    logic            ld_elig;
    logic            grant_alu;
    logic            grant_ld;
    logic            ld_unexpected;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        alu_elig      = alu_valid & ~busy[alu_rd];
        ld_elig       = ld_valid;
        // On a tie the requester that did not win last time gets the port
        grant_alu     = alu_elig & (~ld_elig | (rr_last == RR_LD));
        grant_ld      = ld_elig & (~alu_elig | (rr_last == RR_ALU));
        alu_ready     = grant_alu;
        ld_ready      = grant_ld;
        ld_unexpected = grant_ld & (ld_rd != '0) & ~busy[ld_rd];
        stall         = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

        // Clear before set so a re-issue to the returning register stays outstanding
        busy_nxt = busy;
        if (grant_ld)
            busy_nxt[ld_rd] = 1'b0;
        if (issue_vld)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3     <= 1'b0;
            AD3     <= '0;
            WD3     <= '0;
            busy    <= '0;
            sb_err  <= 1'b0;
            rr_last <= RR_LD;
        end else begin
            WE3 <= 1'b0;
            if (grant_alu) begin
                WE3     <= (alu_rd != '0);
                AD3     <= alu_rd;
                WD3     <= alu_data;
                rr_last <= RR_ALU;
            end else if (grant_ld) begin
                WE3     <= (ld_rd != '0);
                AD3     <= ld_rd;
                WD3     <= ld_data;
                rr_last <= RR_LD;
            end
            busy <= busy_nxt;
            if (ld_unexpected)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a set/array-level model checked every cycle,
// plus literal expectations taken from the documented test scenarios.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, ld_valid = 1'b0, issue_vld = 1'b0;
    logic [AW-1:0] alu_rd = '0, ld_rd = '0, issue_rd = '0;
    logic [AW-1:0] chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic [DW-1:0] alu_data = '0, ld_data = '0;
    logic          alu_ready, ld_ready, stall, WE3, sb_err;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [NR-1:0] busy;

    wb_port_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .issue_vld(issue_vld), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .stall(stall),
        .WE3(WE3), .AD3(AD3), .WD3(WD3), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: set of registers with loads outstanding, last winner, expected write-port contents
    bit            m_pending[NR];
    int            m_last_winner;   // 0 = ALU, 1 = load
    bit            m_err;
    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;

    function automatic void who_wins(output bit ga, output bit gl);
        bit alu_ok, ld_ok;
        alu_ok = alu_valid && !m_pending[alu_rd];
        ld_ok  = ld_valid;
        if (alu_ok && ld_ok) begin
            ga = (m_last_winner != 0);
            gl = !ga;
        end else begin
            ga = alu_ok;
            gl = ld_ok;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit ga, gl;
        if (!rst_n) begin
            foreach (m_pending[i]) m_pending[i] = 1'b0;
            m_last_winner = 1;
            m_err = 1'b0;
            m_we = 1'b0;
            m_ad = '0;
            m_wd = '0;
        end else begin
            who_wins(ga, gl);
            m_we = 1'b0;
            if (ga) begin
                m_we = (alu_rd != 0); m_ad = alu_rd; m_wd = alu_data; m_last_winner = 0;
            end else if (gl) begin
                m_we = (ld_rd != 0); m_ad = ld_rd; m_wd = ld_data; m_last_winner = 1;
            end
            if (gl && ld_rd != 0 && !m_pending[ld_rd]) m_err = 1'b1;
            if (gl) m_pending[ld_rd] = 1'b0;
            if (issue_vld && issue_rd != 0) m_pending[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit ga, gl;
        logic [NR-1:0] mb;
        who_wins(ga, gl);
        for (int i = 0; i < NR; i++) mb[i] = m_pending[i];
        check("model_alu_ready", 64'(alu_ready), 64'(ga));
        check("model_ld_ready",  64'(ld_ready),  64'(gl));
        check("model_stall", 64'(stall),
              64'(m_pending[chk_rs1] || m_pending[chk_rs2] || m_pending[chk_rd]));
        check("model_WE3", 64'(WE3), 64'(m_we));
        check("model_AD3", 64'(AD3), 64'(m_ad));
        check("model_WD3", 64'(WD3), 64'(m_wd));
        check("model_busy", 64'(busy), 64'(mb));
        check("model_sb_err", 64'(sb_err), 64'(m_err));
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0; issue_vld = 0;
        alu_rd = '0; ld_rd = '0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        alu_data = '0; ld_data = '0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    initial begin
        // Reset state
        reset_dut();
        #1;
        check("rst_WE3", 64'(WE3), 64'd0);
        check("rst_AD3", 64'(AD3), 64'd0);
        check("rst_WD3", 64'(WD3), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sb_err", 64'(sb_err), 64'd0);

        // ALU only
        nxt();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("t1_alu_ready", 64'(alu_ready), 64'd1);
        nxt();
        idle();
        #1;
        check("t1_WE3", 64'(WE3), 64'd1);
        check("t1_AD3", 64'(AD3), 64'd5);
        check("t1_WD3", 64'(WD3), 64'hDEADBEEF);

        // Tie: ALU first after reset, then alternate
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 3; alu_data = 32'hA000_0000 + i;
            ld_valid = 1; ld_rd = 4; ld_data = 32'hB000_0000 + i;
            #1;
            check("t2_alu_grant", 64'(alu_ready), 64'((i % 2) == 0));
            check("t2_ld_grant",  64'(ld_ready),  64'((i % 2) == 1));
            if (i > 0) check("t2_WE3_pulse", 64'(WE3), 64'd1);
            nxt();
        end
        idle();
        #1;
        check("t2_last_AD3", 64'(AD3), 64'd4);
        check("t2_last_WD3", 64'(WD3), 64'hB000_0003);

        // Scoreboard / stall / WAW block
        reset_dut();
        issue_vld = 1; issue_rd = 7;
        nxt();
        issue_vld = 0; chk_rs1 = 7;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h1234_5678;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h0000_0077;
        #1;
        check("t3_busy7", 64'(busy[7]), 64'd1);
        check("t3_stall", 64'(stall), 64'd1);
        check("t3_alu_blocked", 64'(alu_ready), 64'd0);
        check("t3_ld_ready", 64'(ld_ready), 64'd1);
        nxt();
        ld_valid = 0;
        #1;
        check("t3_busy7_clr", 64'(busy[7]), 64'd0);
        check("t3_stall_clr", 64'(stall), 64'd0);
        check("t3_ld_AD3", 64'(AD3), 64'd7);
        check("t3_ld_WD3", 64'(WD3), 64'h77);
        check("t3_alu_now_ready", 64'(alu_ready), 64'd1);
        nxt();
        idle();
        #1 check("t3_alu_WD3", 64'(WD3), 64'h1234_5678);

        // x0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
        #1 check("t4_alu_ready_x0", 64'(alu_ready), 64'd1);
        nxt();
        idle();
        issue_vld = 1; issue_rd = 0;
        #1 check("t4_WE3_x0", 64'(WE3), 64'd0);
        nxt();
        idle();
        #1 check("t4_busy_x0", 64'(busy), 64'd0);

        // Same-cycle set and clear, then load to a non-busy register
        issue_vld = 1; issue_rd = 9;
        nxt();
        ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
        #1 check("t5_ld_ready9", 64'(ld_ready), 64'd1);
        nxt();
        idle();
        #1;
        check("t5_busy9_set_wins", 64'(busy[9]), 64'd1);
        check("t5_no_err", 64'(sb_err), 64'd0);
        ld_valid = 1; ld_rd = 12; ld_data = 32'hC;
        nxt();
        idle();
        #1 check("t5_err", 64'(sb_err), 64'd1);
        check("t5_write_proceeds", 64'(AD3), 64'd12);
        nxt();
        nxt();
        #1 check("t5_err_sticky", 64'(sb_err), 64'd1);

        // Async reset mid-cycle with a grant pending
        reset_dut();
        issue_vld = 1; issue_rd = 3;
        alu_valid = 1; alu_rd = 6; alu_data = 32'hAA;
        nxt();
        issue_vld = 0; alu_data = 32'hBB;
        #1 check("t6_pre_WE3", 64'(WE3), 64'd1);
        rst_n = 0;
        #1;
        check("t6_WE3", 64'(WE3), 64'd0);
        check("t6_AD3", 64'(AD3), 64'd0);
        check("t6_WD3", 64'(WD3), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_sb_err", 64'(sb_err), 64'd0);
        idle();
        @(posedge clk);
        #2 rst_n = 1;
        nxt();
        #1;
        check("t6_no_WE3_after", 64'(WE3), 64'd0);
        check("t6_busy_after", 64'(busy), 64'd0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
